fixed_point_divider: RTL and testbench

FIXED_POINT_DIVIDER -- requirements
Module: fixed_point_divider

---
 rtl/fixed_point_pkg.sv | 25 ++
 rtl/fixed_point_sat.sv | 38 +++
 rtl/fixed_point_divider.sv | 146 ++++++++++++++
 tb/tb_fixed_point_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks (divider, multiplier):
// format defaults, FSM state encoding and saturation limit helpers.
package fixed_point_pkg;

    localparam int unsigned DEFAULT_BITSIZE   = 14;
    localparam int unsigned DEFAULT_FRAC_BITS = 7;
    localparam int unsigned LIMIT_W           = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } fp_state_e;

    // Largest positive value of a signed word of the given width.
    function automatic logic [LIMIT_W-1:0] sat_pos_limit(input int unsigned width);
        return (LIMIT_W'(1) << (width - 1)) - LIMIT_W'(1);
    endfunction

    // Magnitude of the most negative value of a signed word of the given width.
    function automatic logic [LIMIT_W-1:0] sat_neg_limit(input int unsigned width);
        return LIMIT_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_sat.sv
// Sign restoration and saturation of an unsigned magnitude into a signed
// two's-complement word; purely combinational.
module fixed_point_sat
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_BITSIZE,
    parameter int unsigned MAG_W = DEFAULT_BITSIZE + DEFAULT_FRAC_BITS
) (
    input  logic             neg_i,
    input  logic [MAG_W-1:0] mag_i,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [LIMIT_W-1:0] POS_LIM = sat_pos_limit(WIDTH);
    localparam logic [LIMIT_W-1:0] NEG_LIM = sat_neg_limit(WIDTH);
    localparam logic [WIDTH-1:0]   MAX_POS = WIDTH'(POS_LIM);
    localparam logic [WIDTH-1:0]   MIN_NEG = WIDTH'(NEG_LIM);

    logic [LIMIT_W-1:0] mag_ext;
    logic [WIDTH-1:0]   mag_low;
    logic [WIDTH-1:0]   neg_low;

    always_comb begin
        mag_ext  = LIMIT_W'(mag_i);
        mag_low  = mag_ext[WIDTH-1:0];
        neg_low  = '0 - mag_low;
        result_o = '0;
        if (mag_ext == '0) begin
            result_o = '0;
        end else if (!neg_i) begin
            result_o = (mag_ext > POS_LIM) ? MAX_POS : mag_low;
        end else begin
            // A magnitude of exactly 2^(WIDTH-1) is representable only when negative.
            result_o = (mag_ext >= NEG_LIM) ? MIN_NEG : neg_low;
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// Signed fixed-point divider: restoring division of |a|<<FRAC_BITS by |b|, one
// quotient bit per cycle, followed by sign restoration and saturation.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int unsigned bitsize   = DEFAULT_BITSIZE,
    parameter int unsigned FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_flag,
    input  logic signed [bitsize-1:0] a,
    input  logic signed [bitsize-1:0] b,
    output logic signed [bitsize-1:0] Div_result,
    output logic                      valid,
    output logic                      busy,
    output logic                      div_by_zero
);

    localparam int unsigned STEPS = bitsize + FRAC_BITS;
    localparam int unsigned CNT_W = $clog2(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    fp_state_e          state_q, state_d;
    logic               neg_q, neg_d;
    logic               zero_q, zero_d;
    logic [STEPS-1:0]   dvd_q, dvd_d;
    logic [STEPS-1:0]   quo_q, quo_d;
    logic [bitsize-1:0] dvs_q, dvs_d;
    logic [bitsize-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [bitsize-1:0] result_q, result_d;
    logic               valid_q, valid_d;
    logic               dbz_q, dbz_d;

    logic [bitsize-1:0] a_u, b_u, abs_a, abs_b;
    logic [bitsize:0]   rem_sh, rem_sub;
    logic [bitsize-1:0] sat_out;

    fixed_point_sat #(
        .WIDTH (bitsize),
        .MAG_W (STEPS)
    ) u_sat (
        .neg_i    (neg_q),
        .mag_i    (quo_q),
        .result_o (sat_out)
    );

    always_comb begin
        a_u     = a;
        b_u     = b;
        abs_a   = a_u[bitsize-1] ? ('0 - a_u) : a_u;
        abs_b   = b_u[bitsize-1] ? ('0 - b_u) : b_u;
        rem_sh  = {rem_q, dvd_q[STEPS-1]};
        rem_sub = rem_sh - {1'b0, dvs_q};

        state_d  = state_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_flag) begin
                    neg_d  = a_u[bitsize-1] ^ b_u[bitsize-1];
                    zero_d = (b_u == '0);
                    dvd_d  = STEPS'(abs_a) << FRAC_BITS;
                    dvs_d  = abs_b;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (b_u == '0) begin
                        // All-ones magnitude saturates to max/min according to sign(a).
                        quo_d   = '1;
                        state_d = ST_DONE;
                    end else begin
                        quo_d   = '0;
                        state_d = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                dvd_d = dvd_q << 1;
                // No borrow out of the trial subtraction means the divisor fits.
                if (!rem_sub[bitsize]) begin
                    rem_d = rem_sub[bitsize-1:0];
                end else begin
                    rem_d = rem_sh[bitsize-1:0];
                end
                quo_d = {quo_q[STEPS-2:0], ~rem_sub[bitsize]};
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                result_d = sat_out;
                valid_d  = 1'b1;
                dbz_d    = zero_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            dvd_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Div_result  = result_q;
    assign valid       = valid_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: stimulus queues expected results,
// a negedge monitor pops and compares whenever valid is seen.
module tb_fixed_point_divider;

    localparam int W   = 14;
    localparam int LAT = 22;

    logic                clk;
    logic                rst;
    logic                start_flag;
    logic signed [W-1:0] a, b;
    logic signed [W-1:0] Div_result;
    logic                valid, busy, div_by_zero;

    fixed_point_divider #(.bitsize(14), .FRAC_BITS(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_flag  (start_flag),
        .a           (a),
        .b           (b),
        .Div_result  (Div_result),
        .valid       (valid),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int unsigned  cyc;
        int           tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc;
    int          total, passed, dbz_viol, valid_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (!valid && div_by_zero) dbz_viol++;
            if (valid) begin
                valid_count++;
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_valid: valid=1 at cycle %0d, expected no strobe", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("result[%0d]", mon_e.tag), {18'b0, Div_result}, {18'b0, mon_e.res});
                    check($sformatf("div_by_zero[%0d]", mon_e.tag), {31'b0, div_by_zero}, {31'b0, mon_e.dbz});
                    check($sformatf("latency[%0d]", mon_e.tag), cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] res, input logic dbz, input int unsigned at, input int tag);
        exp_t e;
        e.res = res;
        e.dbz = dbz;
        e.cyc = at;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                         input logic [W-1:0] res, input logic dbz, input int tag, input bit expect_res);
        a          = av;
        b          = bv;
        start_flag = 1'b1;
        @(posedge clk);
        #1;
        start_flag = 1'b0;
        if (expect_res) push_exp(res, dbz, cyc + ((bv == 0) ? 1 : LAT), tag);
    endtask

    task automatic wait_drain(input int tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check($sformatf("drain[%0d]", tag), sb.size(), 0);
        sb.delete();
    endtask

    int           va [11] = '{384, -217, 1, 8191, -8192, -5, 5, -384, -1, 0, 0};
    int           vb [11] = '{192, 217, 3, 1, 1, 0, 0, -192, 3, -5, 0};
    logic [W-1:0] vr [11] = '{14'h0100, 14'h3F80, 14'h002A, 14'h1FFF, 14'h2000, 14'h2000,
                              14'h1FFF, 14'h0100, 14'h3FD6, 14'h0000, 14'h1FFF};
    logic         vd [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int unsigned acc;
        int          vc0;
        total = 0; passed = 0; dbz_viol = 0; valid_count = 0;
        rst = 1'b0; start_flag = 1'b0; a = '0; b = '0;
        #12;
        check("reset_result", {18'b0, Div_result}, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_dbz", {31'b0, div_by_zero}, 32'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            issue(W'(va[i]), W'(vb[i]), vr[i], vd[i], i, 1'b1);
            check($sformatf("busy_after_start[%0d]", i), {31'b0, busy}, 32'h1);
            wait_drain(i);
        end

        // start held high while busy, operands churning
        a = 14'sd384; b = 14'sd192; start_flag = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        push_exp(14'h0100, 1'b0, acc + LAT, 100);
        for (int k = 1; k <= LAT; k++) begin
            a = W'($urandom);
            b = (k % 5 == 0) ? '0 : W'($urandom);
            @(posedge clk);
            #1;
        end
        check("b2b_valid_edge22", {31'b0, valid}, 32'h1);
        a = 14'sd1; b = 14'sd3;
        @(posedge clk);
        #1;
        start_flag = 1'b0;
        check("b2b_accept_after_valid", {31'b0, busy}, 32'h1);
        push_exp(14'h002A, 1'b0, cyc + LAT, 101);
        wait_drain(101);

        // reset in the middle of a division
        issue(14'sd384, 14'sd192, 14'h0100, 1'b0, 200, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_result", {18'b0, Div_result}, 32'h0);
        check("midrst_valid", {31'b0, valid}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_dbz", {31'b0, div_by_zero}, 32'h0);
        @(negedge clk) rst = 1'b1;
        vc0 = valid_count;
        repeat (40) @(posedge clk);
        #1;
        check("no_strobe_after_abort", valid_count - vc0, 0);
        check("idle_after_abort", {31'b0, busy}, 32'h0);

        issue(14'sd5, 14'sd0, 14'h1FFF, 1'b1, 201, 1'b1);
        wait_drain(201);

        check("dbz_low_without_valid", dbz_viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
